// File: rtl/reg_file_dump_reader_if.sv
// Bus between the register-file dump sequencer, the register file read
// ports and the downstream consumer of the dumped register pairs.
interface reg_file_dump_reader_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [3:0]       source_address_1;
  logic [3:0]       source_address_2;
  logic [WIDTH-1:0] out_data_lo;
  logic [WIDTH-1:0] out_data_hi;
  logic [2:0]       out_pair;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  // Sequencer side.
  modport master (
    input  start, rd1, rd2, out_ready,
    output source_address_1, source_address_2,
           out_data_lo, out_data_hi, out_pair, out_valid, busy, done
  );

  // Register file plus downstream consumer side.
  modport slave (
    output start, rd1, rd2, out_ready,
    input  source_address_1, source_address_2,
           out_data_lo, out_data_hi, out_pair, out_valid, busy, done
  );
endinterface

// File: rtl/reg_file_dump_reader.sv
// Walks the register file two registers per beat (even/odd pair) through
// its two read ports and streams the pairs out on a valid/ready handshake.
// Read-only: the file's write port is never touched.
//
// state   | meaning
// IDLE    | waiting for start
// CAPTURE | read ports addressed by pair; data latched at the next edge
// SEND    | beat held valid until out_ready
// FINISH  | one-cycle done pulse, then back to IDLE
module reg_file_dump_reader #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_file_dump_reader_if.master bus
);

  localparam logic [2:0] LAST_PAIR = 3'(NUM_REGS / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND,
    FINISH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       pair;
  logic [WIDTH-1:0] data_lo;
  logic [WIDTH-1:0] data_hi;
  logic [2:0]       beat_pair;
  logic             valid;
  logic             handshake;

  assign handshake = valid & bus.out_ready;

  // Addresses follow the pair counter directly; the file read path is
  // combinational, so rd1/rd2 are usable in the same cycle.
  assign bus.source_address_1 = {pair, 1'b0};
  assign bus.source_address_2 = {pair, 1'b1};
  assign bus.out_data_lo      = data_lo;
  assign bus.out_data_hi      = data_hi;
  assign bus.out_pair         = beat_pair;
  assign bus.out_valid        = valid;
  assign bus.busy             = (state != IDLE);
  assign bus.done             = (state == FINISH);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND:    if (handshake) state_nxt = (pair == LAST_PAIR) ? FINISH : CAPTURE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pair counter and beat registers; the beat is frozen once captured so
  // register writes during a stall cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair      <= '0;
      data_lo   <= '0;
      data_hi   <= '0;
      beat_pair <= '0;
      valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) pair <= '0;
        end
        CAPTURE: begin
          data_lo   <= bus.rd1;
          data_hi   <= bus.rd2;
          beat_pair <= pair;
          valid     <= 1'b1;
        end
        SEND: begin
          if (handshake) begin
            valid <= 1'b0;
            // Counter stops at the last pair so unused addresses never appear.
            if (pair != LAST_PAIR) pair <= pair + 3'd1;
          end
        end
        FINISH: begin
          pair <= '0;
        end
        default: begin
          pair  <= '0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
